ex_div_unit: RTL and testbench

- Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU) in the execute stage of the 3-stage core.
- Accepts operands and destination register from decode, then iterates a radix-2 restoring division.
- Drives the register-file write port (reg_waddr/reg_wdata/reg_wen) for one cycle when the result is ready.
- Requests a pipeline stall while a division is in flight.

---
 rtl/ex_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_ex_div_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) for the execute stage.
// Runs a radix-2 restoring division over XLEN iterations on operand magnitudes
// and fixes the sign at the end. The RV32M special cases (divide by zero and
// signed overflow) are resolved when the operation is accepted, so they
// complete one cycle after acceptance.
//
// state | meaning
// IDLE  | no operation in flight; a new one can be accepted
// CALC  | one restoring step per clock; pipeline stalled
// DONE  | result presented on the write port for one cycle; can accept again
module ex_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            div_start,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] div_dividend,
   input  logic [XLEN-1:0] div_divisor,
   input  logic [4:0]      div_rd,
   input  logic            flush,
   output logic            div_busy,
   output logic            div_stall_req,
   output logic [4:0]      reg_waddr,
   output logic [XLEN-1:0] reg_wdata,
   output logic            reg_wen
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            op_rem_q, op_rem_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] quot_q, quot_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;

   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic            div_by_zero;
   logic            sgn_ovf;
   logic            special;
   logic            accept;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] trial;
   logic [XLEN-1:0] q_res;
   logic [XLEN-1:0] r_res;
   logic [XLEN-1:0] result;

   // Operand conditioning and special-case detection on the incoming request.
   always_comb begin
      is_signed   = ~div_op[0];
      a_neg       = is_signed & div_dividend[XLEN-1];
      b_neg       = is_signed & div_divisor[XLEN-1];
      a_abs       = a_neg ? (~div_dividend + 1'b1) : div_dividend;
      b_abs       = b_neg ? (~div_divisor + 1'b1) : div_divisor;
      div_by_zero = (div_divisor == '0);
      sgn_ovf     = is_signed
                    & (div_dividend == {1'b1, {(XLEN-1){1'b0}}})
                    & (div_divisor == {XLEN{1'b1}});
      special     = div_by_zero | sgn_ovf;
      accept      = div_start & ~flush & (state_q != ST_CALC);
   end

   // One restoring step and the sign-corrected final result.
   always_comb begin
      rem_sh = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
      trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
      q_res  = q_neg_q ? (~quot_q + 1'b1) : quot_q;
      r_res  = r_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
      result = op_rem_q ? r_res : q_res;
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_rem_d = op_rem_q;
      rd_d     = rd_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      case (state_q)
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               if (!trial[XLEN+1]) begin
                  rem_d  = trial[XLEN:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d  = rem_sh;
                  quot_d = {quot_q[XLEN-2:0], 1'b0};
               end
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_rem_d = div_op[1];
               rd_d     = div_rd;
               cnt_d    = '0;
               if (div_by_zero) begin
                  // Quotient all ones, remainder is the raw dividend; no sign fix.
                  quot_d  = {XLEN{1'b1}};
                  rem_d   = {1'b0, div_dividend};
                  dvs_d   = '0;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = ST_DONE;
               end else if (sgn_ovf) begin
                  quot_d  = {1'b1, {(XLEN-1){1'b0}}};
                  rem_d   = '0;
                  dvs_d   = '0;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  quot_d  = a_abs;
                  rem_d   = '0;
                  dvs_d   = b_abs;
                  q_neg_d = a_neg ^ b_neg;
                  r_neg_d = a_neg;
                  state_d = ST_CALC;
               end
            end
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_rem_q <= 1'b0;
         rd_q     <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_rem_q <= op_rem_d;
         rd_q     <= rd_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
      end
   end

   // Stall, busy and register-file write port; the write port is idle outside DONE.
   always_comb begin
      div_busy      = 1'b0;
      div_stall_req = 1'b0;
      reg_waddr     = '0;
      reg_wdata     = '0;
      reg_wen       = 1'b0;
      if (state_q == ST_CALC) begin
         div_busy      = 1'b1;
         div_stall_req = 1'b1;
      end else begin
         div_stall_req = div_start & ~special;
      end
      if (state_q == ST_DONE) begin
         reg_waddr = rd_q;
         reg_wdata = result;
         reg_wen   = (rd_q != 5'd0) & ~flush;
      end
   end

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: an arithmetic reference model plus an abstract
// timeline (idle / computing with N cycles left / result cycle) is compared
// against the DUT outputs every cycle, with directed and randomized requests.
module tb_ex_div_unit;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        div_start;
   logic [1:0]  div_op;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [4:0]  div_rd;
   logic        flush;
   logic        div_busy;
   logic        div_stall_req;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_wen;

   int checks   = 0;
   int failures = 0;

   ex_div_unit #(.XLEN(32), .CNT_W(5)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .div_start     (div_start),
      .div_op        (div_op),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_rd        (div_rd),
      .flush         (flush),
      .div_busy      (div_busy),
      .div_stall_req (div_stall_req),
      .reg_waddr     (reg_waddr),
      .reg_wdata     (reg_wdata),
      .reg_wen       (reg_wen)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference arithmetic following the RV32M rules.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      int sa;
      int sb;
      logic [31:0] q;
      logic [31:0] r;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (!op[0]) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Abstract timeline: 0 idle, 1 computing, 2 result cycle.
   int          m_state = 0;
   int          m_left  = 0;
   logic [31:0] m_res   = '0;
   logic [4:0]  m_rd    = '0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_state = 0;
         m_left  = 0;
         m_res   = '0;
         m_rd    = '0;
      end else if (m_state == 1) begin
         if (flush) m_state = 0;
         else begin
            m_left--;
            if (m_left == 0) m_state = 2;
         end
      end else begin
         m_state = 0;
         if (div_start && !flush) begin
            m_res   = ref_div(div_op, div_dividend, div_divisor);
            m_rd    = div_rd;
            m_left  = 32;
            m_state = is_special(div_op, div_dividend, div_divisor) ? 2 : 1;
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-low-phase.
   always @(negedge sys_clk) begin
      logic e_stall;
      #3;
      e_stall = (m_state == 1) ||
                (div_start && m_state != 1 && !is_special(div_op, div_dividend, div_divisor));
      chk("busy", 32'(div_busy), 32'(m_state == 1));
      chk("stall", 32'(div_stall_req), 32'(e_stall));
      chk("wen", 32'(reg_wen), 32'(m_state == 2 && m_rd != 5'd0 && !flush));
      chk("waddr", 32'(reg_waddr), (m_state == 2) ? 32'(m_rd) : 32'd0);
      chk("wdata", reg_wdata, (m_state == 2) ? m_res : 32'd0);
   end

   // Issue one request (from IDLE or DONE, called just after a falling edge),
   // wait for its result cycle and check the result and stall length.
   task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_stall);
      int stalls = 0;
      int cyc = 0;
      div_op = op; div_dividend = a; div_divisor = b; div_rd = rd;
      div_start = 1'b1;
      #1;
      if (div_stall_req) stalls++;
      @(posedge sys_clk); #1;
      div_start = 1'b0;
      while (m_state != 2 && cyc < 100) begin
         @(negedge sys_clk); #1;
         if (div_stall_req) stalls++;
         @(posedge sys_clk); #1;
         cyc++;
      end
      if (cyc >= 100) chk({nm, "_timeout"}, 32'(cyc), 32'd0);
      @(negedge sys_clk); #1;
      chk({nm, "_wdata"}, reg_wdata, exp);
      chk({nm, "_wen"}, 32'(reg_wen), 32'(rd != 5'd0));
      chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stall));
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom % 6)
         0: return 32'($urandom % 20);
         1: return 32'd0;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int wen_seen;
      sys_rst_n = 1'b0;
      div_start = 1'b0; div_op = 2'b00; div_dividend = '0; div_divisor = '0;
      div_rd = '0; flush = 1'b0;
      #1;
      chk("rst_busy", 32'(div_busy), 32'd0);
      chk("rst_wen", 32'(reg_wen), 32'd0);
      chk("rst_wdata", reg_wdata, 32'd0);
      #20 sys_rst_n = 1'b1;

      chk("ref_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
      chk("ref_div_neg", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("ref_rem_neg", ref_div(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
      chk("ref_remu_z", ref_div(2'b11, 32'd55, 32'd0), 32'd55);

      @(negedge sys_clk);
      do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
      repeat (2) @(negedge sys_clk);
      do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 33);
      repeat (2) @(negedge sys_clk);
      do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
      repeat (2) @(negedge sys_clk);
      do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 33);
      repeat (2) @(negedge sys_clk);
      do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 33);
      repeat (2) @(negedge sys_clk);
      do_op("divu_by0", 2'b01, 32'd55, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
      repeat (2) @(negedge sys_clk);
      do_op("rem_by0", 2'b10, 32'd55, 32'd0, 5'd6, 32'd55, 0);
      repeat (2) @(negedge sys_clk);
      do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 0);
      repeat (2) @(negedge sys_clk);
      do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 0);

      // Flush at iteration 10.
      repeat (2) @(negedge sys_clk);
      div_op = 2'b01; div_dividend = 32'd1000; div_divisor = 32'd3; div_rd = 5'd8;
      div_start = 1'b1;
      @(posedge sys_clk); #1 div_start = 1'b0;
      repeat (10) @(posedge sys_clk);
      @(negedge sys_clk) flush = 1'b1;
      @(posedge sys_clk); #1 flush = 1'b0;
      @(negedge sys_clk); #1;
      chk("flush_busy", 32'(div_busy), 32'd0);
      wen_seen = 0;
      repeat (40) begin
         @(negedge sys_clk); #1;
         if (reg_wen) wen_seen++;
      end
      chk("flush_no_write", 32'(wen_seen), 32'd0);
      do_op("after_flush", 2'b01, 32'd9, 32'd3, 5'd8, 32'd3, 33);

      // rd=0 then back-to-back from DONE.
      repeat (2) @(negedge sys_clk);
      do_op("rd0", 2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 33);
      do_op("b2b", 2'b01, 32'd20, 32'd4, 5'd7, 32'd5, 33);

      // Asynchronous reset mid-computation.
      repeat (2) @(negedge sys_clk);
      div_op = 2'b01; div_dividend = 32'd1000; div_divisor = 32'd3; div_rd = 5'd9;
      div_start = 1'b1;
      @(posedge sys_clk); #1 div_start = 1'b0;
      repeat (5) @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(div_busy), 32'd0);
      chk("arst_stall", 32'(div_stall_req), 32'd0);
      chk("arst_wdata", reg_wdata, 32'd0);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      wen_seen = 0;
      repeat (40) begin
         @(negedge sys_clk); #1;
         if (reg_wen) wen_seen++;
      end
      chk("arst_no_write", 32'(wen_seen), 32'd0);

      // Randomized traffic; the per-cycle comparison does the checking.
      repeat (3000) begin
         @(negedge sys_clk); #1;
         div_start    = ($urandom % 3) == 0;
         div_op       = 2'($urandom);
         div_dividend = rnd_opnd();
         div_divisor  = rnd_opnd();
         div_rd       = 5'($urandom);
         flush        = ($urandom % 40) == 0;
      end
      @(negedge sys_clk); #1;
      div_start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge sys_clk);
      #4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
